// File: rtl/mux_4_1.sv
// mux_4_1: registered 4-to-1 multiplexer.
// One of four equal-width sources is chosen by a 2-bit select and the
// chosen word is captured into the output register on every rising clock
// edge. There is no enable: the output reloads each cycle. A synchronous
// active-high reset clears the output and takes priority over selection.
module mux_4_1 #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] p0,
    input  logic [WIDTH-1:0] p1,
    input  logic [WIDTH-1:0] p2,
    input  logic [WIDTH-1:0] p3,
    output logic [WIDTH-1:0] sout
);

    logic [WIDTH-1:0] mux_d_s;
    logic [WIDTH-1:0] sout_r;

    // Source select; an unknown select drives X so it is never masked in simulation.
    always_comb begin
        mux_d_s = {WIDTH{1'b0}};
        case (sel)
            2'd0:    mux_d_s = p0;
            2'd1:    mux_d_s = p1;
            2'd2:    mux_d_s = p2;
            2'd3:    mux_d_s = p3;
            default: mux_d_s = {WIDTH{1'bx}};
        endcase
    end

    // Output register: reset wins on its edge, otherwise load the selected word.
    always_ff @(posedge clk) begin
        if (rst) begin
            sout_r <= {WIDTH{1'b0}};
        end else begin
            sout_r <= mux_d_s;
        end
    end

    assign sout = sout_r;

endmodule

// File: tb/tb_mux_4_1.sv
// tb_mux_4_1: self-checking bench for mux_4_1.
// A 2-bit instance runs a directed vector table, hand-written corner
// sequences and a randomized phase against a behavioural reference
// (output = 0 under reset, otherwise the indexed source). An 8-bit
// instance covers the width override.
module tb_mux_4_1;

    typedef struct {
        string      name;
        logic       rst;
        logic [1:0] sel;
        logic [1:0] p0;
        logic [1:0] p1;
        logic [1:0] p2;
        logic [1:0] p3;
        logic [1:0] exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [1:0] sel;
    logic [1:0] p0, p1, p2, p3;
    logic [1:0] sout;

    logic       rst8;
    logic [1:0] sel8;
    logic [7:0] q0, q1, q2, q3;
    logic [7:0] sout8;

    int checks;
    int errors;
    vec_t vecs[$];

    mux_4_1 #(.WIDTH(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .sel  (sel),
        .p0   (p0),
        .p1   (p1),
        .p2   (p2),
        .p3   (p3),
        .sout (sout)
    );

    mux_4_1 #(.WIDTH(8)) dut8 (
        .clk  (clk),
        .rst  (rst8),
        .sel  (sel8),
        .p0   (q0),
        .p1   (q1),
        .p2   (q2),
        .p3   (q3),
        .sout (sout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic r, input logic [1:0] s,
                       input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                       input logic [1:0] d, input logic [1:0] e);
        vec_t v;
        v.name = name; v.rst = r; v.sel = s;
        v.p0 = a; v.p1 = b; v.p2 = c; v.p3 = d; v.exp = e;
        vecs.push_back(v);
    endtask

    // Drive one set of inputs between edges, then check one edge later.
    task automatic step(input string name, input logic r, input logic [1:0] s,
                        input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                        input logic [1:0] d, input logic [1:0] e);
        @(negedge clk);
        rst = r; sel = s; p0 = a; p1 = b; p2 = c; p3 = d;
        @(posedge clk);
        #1;
        check(name, {6'd0, sout}, {6'd0, e});
    endtask

    task automatic step8(input string name, input logic r, input logic [1:0] s,
                         input logic [7:0] e);
        @(negedge clk);
        rst8 = r; sel8 = s;
        @(posedge clk);
        #1;
        check(name, sout8, e);
    endtask

    initial begin
        logic [1:0] pv[4];
        logic       rr;
        logic [1:0] ss;
        logic [1:0] ee;

        checks = 0;
        errors = 0;
        rst = 1'b1; sel = 2'd0; p0 = 2'b00; p1 = 2'b01; p2 = 2'b10; p3 = 2'b11;
        rst8 = 1'b1; sel8 = 2'd0;
        q0 = 8'hA5; q1 = 8'h5A; q2 = 8'hFF; q3 = 8'h00;

        // Static sources, reset for two cycles, then the select sweep.
        add("reset0",   1'b1, 2'd0, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00);
        add("reset1",   1'b1, 2'd0, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00);
        add("sel0",     1'b0, 2'd0, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00);
        add("sel3",     1'b0, 2'd3, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11);
        add("sel1",     1'b0, 2'd1, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01);
        add("sel0b",    1'b0, 2'd0, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00);
        add("sel2",     1'b0, 2'd2, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10);
        // Reset held with sel=3, then released: no dead cycle.
        add("rst_sel3a",1'b1, 2'd3, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00);
        add("rst_sel3b",1'b1, 2'd3, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00);
        add("release",  1'b0, 2'd3, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11);
        // Reset mid-stream discards the selected value.
        add("mid_s1",   1'b0, 2'd1, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01);
        add("mid_rst",  1'b1, 2'd2, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00);
        add("mid_s3",   1'b0, 2'd3, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11);
        // Data tracking on p2 while the unselected sources toggle.
        add("trk00",    1'b0, 2'd2, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00);
        add("trk01",    1'b0, 2'd2, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        add("trk10",    1'b0, 2'd2, 2'b11, 2'b11, 2'b10, 2'b11, 2'b10);
        add("trk11",    1'b0, 2'd2, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11);

        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].rst, vecs[i].sel, vecs[i].p0, vecs[i].p1,
                 vecs[i].p2, vecs[i].p3, vecs[i].exp);
        end

        // Glitch between edges: sel leaves and returns before the edge.
        step("glitch_pre", 1'b0, 2'd1, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01);
        #1 sel = 2'd3;
        #1;
        check("no_comb_path", {6'd0, sout}, 8'h01);
        #1 sel = 2'd2;
        #1 sel = 2'd1;
        @(posedge clk);
        #1;
        check("glitch_post", {6'd0, sout}, 8'h01);

        // Randomized phase against the reference model.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rr = ($urandom_range(0, 15) == 0);
            ss = 2'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) pv[k] = 2'($urandom_range(0, 3));
            rst = rr; sel = ss; p0 = pv[0]; p1 = pv[1]; p2 = pv[2]; p3 = pv[3];
            ee = rr ? 2'b00 : pv[ss];
            @(posedge clk);
            #1;
            check("random", {6'd0, sout}, {6'd0, ee});
        end

        // Width override: 8-bit sources.
        step8("w8_reset", 1'b1, 2'd0, 8'h00);
        step8("w8_sel0",  1'b0, 2'd0, 8'hA5);
        step8("w8_sel1",  1'b0, 2'd1, 8'h5A);
        step8("w8_sel2",  1'b0, 2'd2, 8'hFF);
        step8("w8_sel3",  1'b0, 2'd3, 8'h00);
        step8("w8_sel2b", 1'b0, 2'd2, 8'hFF);
        step8("w8_reset2",1'b1, 2'd2, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
